seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter LZ_BLANK, default 1, 1 = leading-zero blanking enabled.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_valid_i  input  1  a 16-bit display value is offered on load_value_i.
REQ-006 load_value_i  input  16  hex value to show; nibble 0 = rightmost digit.
REQ-007 load_ready_o  output  1  block can accept a value this cycle.
REQ-008 seg_nibble_o  output  4  nibble of the active digit; feeds the hex-to-segment encoder.
REQ-009 seg_digit_en_o  output  4  active-low digit enables; bit n = digit n.
REQ-010 frame_done_o  output  1  one-cycle pulse when digit 3's slot ends.

Function
REQ-011 A transfer SHALL occur on a rising edge where load_valid_i and load_ready_o are both high.
REQ-012 State machine SHALL have two states:
- BLANK: no value loaded yet; all digits off.
- SCAN: digits are multiplexed.
REQ-013 BLANK -> SCAN on the first transfer; that value SHALL go directly to the display register and digit index SHALL be 0.
REQ-014 SCAN SHALL never return to BLANK except by reset.
REQ-015 Prescaler SHALL count 0..CLK_DIV-1, wrapping to 0.
- tick = (count == CLK_DIV-1).
- Prescaler SHALL hold at 0 in BLANK.
REQ-016 In SCAN, digit index SHALL advance on each tick: 0->1->2->3->0.
REQ-017 Frame boundary SHALL be a tick while index == 3; frame_done_o SHALL be high in exactly that cycle.
REQ-018 A transfer in SCAN SHALL load a one-entry pending buffer and set pend_valid.
REQ-019 load_ready_o SHALL be high whenever pend_valid == 0 (including in BLANK), and low otherwise.
REQ-020 At a frame boundary with pend_valid set, the display register SHALL take the pending value and pend_valid SHALL clear; the value becomes visible with index 0.
REQ-021 A transfer in the same cycle as a frame boundary (pend_valid == 0) SHALL write the display register directly and leave pend_valid clear.
REQ-022 The display register SHALL change only at a frame boundary or on the first transfer, so a partially updated value is never shown.
REQ-023 seg_nibble_o SHALL equal display[4*idx +: 4] in SCAN and 4'h0 in BLANK.
REQ-024 In SCAN, seg_digit_en_o SHALL equal ~(4'b0001 << idx), with digit idx forced off (bit = 1) if blanked.
REQ-025 In BLANK, seg_digit_en_o SHALL be 4'hF.
REQ-026 With LZ_BLANK = 1, digit n (n >= 1) SHALL be blanked when display nibbles n..3 are all zero; digit 0 SHALL never be blanked.
REQ-027 All outputs SHALL be driven from registered state only, with no combinational path from load inputs to outputs.
REQ-028 Output changes SHALL occur in the same cycle as the underlying index or register update (zero added latency).

Reset
REQ-029 While rst is high at a rising edge, the following SHALL be set and any transfer that cycle ignored:
- state = BLANK
- prescaler = 0
- idx = 0
- display = 16'h0000
- pend_valid = 0
REQ-030 Outputs after reset SHALL be: load_ready_o = 1, seg_nibble_o = 4'h0, seg_digit_en_o = 4'hF, frame_done_o = 0.
REQ-031 Reset asserted mid-frame or with a value pending SHALL discard the pending value, with no frame_done_o pulse.

Verification (CLK_DIV = 4, LZ_BLANK = 1)
REQ-032 Reset, then idle 20 cycles -> seg_digit_en_o = 4'hF, load_ready_o = 1, no frame_done_o.
REQ-033 Load 16'h1234 -> next cycle: enable = 4'b1110, nibble = 4;
- every 4 cycles after: enable 1101/3, 1011/2, 0111/1;
- frame_done_o pulses on the 16th cycle.
REQ-034 Load 16'h0050 -> digits 0,1 scanned (nibbles 0, 5); digits 2,3 enable = 1 during their slots; load 16'h0000 -> only digit 0 lit, showing 0.
REQ-035 Mid-frame load 16'hABCD over 16'h1234 -> load_ready_o low until boundary; display remains 1234 until the frame ends, then digit 0 shows D; a second valid held during the pending period is accepted only after the boundary.
REQ-036 Assert valid exactly in the frame_done_o cycle -> direct update, load_ready_o stays 1.
REQ-037 Assert rst with a value pending -> BLANK outputs next cycle; after release, the old pending value never appears.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with a one-entry load buffer.
// New values are committed only at frame boundaries so digits never tear.
module seg_scan_ctrl #(
  parameter int CLK_DIV  = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid_i,
  input  logic [15:0] load_value_i,
  output logic        load_ready_o,
  output logic [3:0]  seg_nibble_o,
  output logic [3:0]  seg_digit_en_o,
  output logic        frame_done_o
);

  typedef enum logic {
    BLANK,
    SCAN
  } state_e;

  localparam logic [19:0] LAST = 20'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;

  logic xfer;
  logic tick;
  logic frame;
  logic lz;

  assign load_ready_o = ~pend_valid_q;
  assign xfer  = load_valid_i & ~pend_valid_q;
  assign tick  = (state_q == SCAN) && (cnt_q == LAST);
  assign frame = tick && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    unique case (state_q)
      BLANK: begin
        cnt_d = '0;
        idx_d = '0;
        if (xfer) begin
          state_d = SCAN;
          disp_d  = load_value_i;
        end
      end
      SCAN: begin
        cnt_d = tick ? '0 : cnt_q + 20'd1;
        if (tick) idx_d = idx_q + 2'd1;
        // A load landing on the boundary itself bypasses the buffer
        if (frame) begin
          if (pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
          end else if (xfer) begin
            disp_d = load_value_i;
          end
        end else if (xfer) begin
          pend_d       = load_value_i;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    lz = 1'b0;
    unique case (idx_q)
      2'd0: lz = 1'b0;
      2'd1: lz = (disp_q[15:4] == 12'h0);
      2'd2: lz = (disp_q[15:8] == 8'h0);
      2'd3: lz = (disp_q[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
  end

  always_comb begin
    seg_nibble_o   = 4'h0;
    seg_digit_en_o = 4'hF;
    frame_done_o   = 1'b0;
    if (state_q == SCAN) begin
      seg_nibble_o   = disp_q[{idx_q, 2'b00} +: 4];
      seg_digit_en_o = ~(4'b0001 << idx_q);
      if (LZ_BLANK && lz) seg_digit_en_o = 4'hF;
      frame_done_o   = frame;
    end
  end

endmodule
